// File: rtl/display_mux_7seg.sv
// Time-multiplexed N-digit 7-segment driver: shadow-captured digit codes, per-digit blank/blink/dp,
// registered pin-level outputs with a dead-time guard at the start of every digit slot.
module display_mux_7seg #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD_CYC      = 2,
  parameter int BLINK_DIV      = 12500000,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [SW-1:0]         slot_idx
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic DIG_OFF = (DIG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // Lit-segment pattern {a,b,c,d,e,f,g}, active-high
  function automatic logic [6:0] decode7(input logic [3:0] code);
    logic [6:0] lit;
    case (code)
      4'd0:    lit = 7'b1111110;
      4'd1:    lit = 7'b0110000;
      4'd2:    lit = 7'b1101101;
      4'd3:    lit = 7'b1111001;
      4'd4:    lit = 7'b0110011;
      4'd5:    lit = 7'b1011011;
      4'd6:    lit = 7'b1011111;
      4'd7:    lit = 7'b1110000;
      4'd8:    lit = 7'b1111111;
      4'd9:    lit = 7'b1111011;
      4'd10:   lit = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000000;
      4'd11:   lit = (HEX_MODE != 0) ? 7'b0011111 : 7'b0000000;
      4'd12:   lit = (HEX_MODE != 0) ? 7'b1001110 : 7'b0000000;
      4'd13:   lit = (HEX_MODE != 0) ? 7'b0111101 : 7'b0000000;
      4'd14:   lit = (HEX_MODE != 0) ? 7'b1001111 : 7'b0000000;
      4'd15:   lit = (HEX_MODE != 0) ? 7'b1000111 : 7'b0000000;
      default: lit = 7'b0000000;
    endcase
    return lit;
  endfunction

  logic [4*DIGITS-1:0] value_r;
  logic [DIGITS-1:0]   blank_r;
  logic [DIGITS-1:0]   blink_r;
  logic [DIGITS-1:0]   shadow_dp_r;
  logic [PW-1:0]       pre_r;
  logic [SW-1:0]       slot_r;
  logic [BW-1:0]       blink_cnt_r;
  logic                blink_off_r;
  logic [6:0]          seg_r;
  logic                dp_out_r;
  logic [DIGITS-1:0]   dig_r;

  logic                pre_wrap_s;
  logic                blink_wrap_s;
  logic [SW-1:0]       slot_next_s;
  logic [3:0]          code_s;
  logic                dark_s;
  logic [6:0]          seg_lit_s;
  logic                dp_lit_s;
  logic [DIGITS-1:0]   dig_on_s;

  // Scan/blink wrap detection and next slot index
  always_comb begin
    pre_wrap_s   = (pre_r == PW'(SCAN_DIV - 1));
    blink_wrap_s = (blink_cnt_r == BW'(BLINK_DIV - 1));
    slot_next_s  = '0;
    if (slot_r == SW'(DIGITS - 1)) begin
      slot_next_s = '0;
    end else begin
      slot_next_s = slot_r + SW'(1);
    end
  end

  // Segment content for the current slot, and guarded one-hot digit enable
  always_comb begin
    code_s    = value_r[{slot_r, 2'b00} +: 4];
    dark_s    = blank_r[slot_r] | (blink_r[slot_r] & blink_off_r);
    seg_lit_s = 7'b0000000;
    dp_lit_s  = 1'b0;
    dig_on_s  = '0;
    if (dark_s) begin
      seg_lit_s = 7'b0000000;
      dp_lit_s  = 1'b0;
    end else begin
      seg_lit_s = decode7(code_s);
      dp_lit_s  = shadow_dp_r[slot_r];
    end
    if (pre_r >= PW'(GUARD_CYC)) begin
      dig_on_s[slot_r] = 1'b1;
    end else begin
      dig_on_s = '0;
    end
  end

  // Shadow registers captured on the load strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r     <= '0;
      blank_r     <= '1;
      blink_r     <= '0;
      shadow_dp_r <= '0;
    end else if (load) begin
      value_r     <= value;
      blank_r     <= blank_mask;
      blink_r     <= blink_mask;
      shadow_dp_r <= dp_in;
    end
  end

  // Slot prescaler and scan index
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_r  <= '0;
      slot_r <= '0;
    end else if (pre_wrap_s) begin
      pre_r  <= '0;
      slot_r <= slot_next_s;
    end else begin
      pre_r  <= pre_r + PW'(1);
    end
  end

  // Free-running blink half-period counter, independent of the scan
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_r <= '0;
      blink_off_r <= 1'b0;
    end else if (blink_wrap_s) begin
      blink_cnt_r <= '0;
      blink_off_r <= ~blink_off_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BW'(1);
    end
  end

  // Pin-level output registers; segments only change at slot start so a slot never glitches
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r    <= {7{SEG_OFF}};
      dp_out_r <= SEG_OFF;
      dig_r    <= {DIGITS{DIG_OFF}};
    end else begin
      if (pre_r == '0) begin
        seg_r    <= seg_lit_s ^ {7{SEG_OFF}};
        dp_out_r <= dp_lit_s ^ SEG_OFF;
      end
      dig_r <= dig_on_s ^ {DIGITS{DIG_OFF}};
    end
  end

  assign seg      = seg_r;
  assign dp       = dp_out_r;
  assign dig_sel  = dig_r;
  assign slot_idx = slot_r;

endmodule
